// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: branch funct3 encodings and the resolve FSM state type.
package pipe_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } brc_state_e;

endpackage

// File: rtl/br_taken_dec.sv
// Combinational branch decode: funct3 + comparator flags -> taken, comparator mode, illegal funct3.
module br_taken_dec
  import pipe_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       brc_less,
  input  logic       brc_equal,
  output logic       br_un,
  output logic       br_taken,
  output logic       illegal_f3
);

  // br_un = 1 selects the signed compare (BLT/BGE); the unsigned forms share the less flag.
  assign br_un = (funct3 == BLT) || (funct3 == BGE);

  always_comb begin
    br_taken   = 1'b0;
    illegal_f3 = 1'b0;
    case (funct3)
      BEQ:        br_taken   = brc_equal;
      BNE:        br_taken   = ~brc_equal;
      BLT, BLTU:  br_taken   = brc_less;
      BGE, BGEU:  br_taken   = ~brc_less;
      default:    illegal_f3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch/jump resolution: same-cycle redirect + flush, or deferred via PEND under stall.
// Optional performance counters are built when BRC_PERF_CNT_EN is defined.
module branch_resolve_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_ex_valid,
  input  logic            i_ex_is_br,
  input  logic            i_ex_is_jmp,
  input  logic            i_ex_is_jalr,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic            i_brc_less,
  input  logic            i_brc_equal,
  input  logic            i_stall,
  output logic            o_br_un,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush_ifid,
  output logic            o_flush_idex,
  output logic            o_illegal
`ifdef BRC_PERF_CNT_EN
  ,
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_taken_cnt
`endif
);

  brc_state_e      state_q, state_d;
  logic [XLEN-1:0] pend_pc_q;
  logic [XLEN-1:0] tgt_masked;
  logic            dec_taken, dec_illegal;
  logic            is_jump, taken, resolve, illegal_cond;
  logic            capture, redirect;

  br_taken_dec u_dec (
    .funct3     (i_ex_funct3),
    .brc_less   (i_brc_less),
    .brc_equal  (i_brc_equal),
    .br_un      (o_br_un),
    .br_taken   (dec_taken),
    .illegal_f3 (dec_illegal)
  );

  // Jumps win over a simultaneously flagged branch, so a jump never reports an illegal funct3.
  assign is_jump      = i_ex_valid & i_ex_is_jmp;
  assign taken        = is_jump | (i_ex_is_br & dec_taken);
  assign resolve      = i_ex_valid & (i_ex_is_br | i_ex_is_jmp) & taken;
  assign illegal_cond = i_ex_valid & i_ex_is_br & ~i_ex_is_jmp & dec_illegal;
  assign tgt_masked   = {i_ex_target[XLEN-1:1],
                         i_ex_target[0] & ~(i_ex_is_jmp & i_ex_is_jalr)};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) pend_pc_q <= tgt_masked;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (resolve && i_stall) begin
          state_d = PEND;
          capture = 1'b1;
        end
      end
      PEND: begin
        if (!i_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    redirect      = 1'b0;
    o_illegal     = 1'b0;
    o_redirect_pc = tgt_masked;
    case (state_q)
      IDLE: begin
        redirect  = resolve & ~i_stall;
        o_illegal = illegal_cond & ~i_stall;
      end
      PEND: begin
        redirect      = ~i_stall;
        o_redirect_pc = pend_pc_q;
      end
      default: ;
    endcase
    // Combinational outputs are gated so reset silences them without waiting for a clock.
    if (!i_reset_n) begin
      redirect  = 1'b0;
      o_illegal = 1'b0;
    end
  end

  assign o_redirect   = redirect;
  assign o_flush_ifid = redirect;
  assign o_flush_idex = redirect;

`ifdef BRC_PERF_CNT_EN
  logic [31:0] br_cnt_q, taken_cnt_q;
  logic        br_inc;

  assign br_inc = ((state_q == IDLE) & ~i_stall & i_ex_valid & (i_ex_is_br | i_ex_is_jmp))
                | capture;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (br_inc)   br_cnt_q    <= br_cnt_q + 32'd1;
      if (redirect) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign o_br_cnt    = br_cnt_q;
  assign o_taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed scoreboard bench for branch_resolve_ctrl; counter checks build when BRC_PERF_CNT_EN is defined.
module tb_branch_resolve_ctrl;
  import pipe_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_ex_valid, i_ex_is_br, i_ex_is_jmp, i_ex_is_jalr;
  logic [2:0]      i_ex_funct3;
  logic [XLEN-1:0] i_ex_target;
  logic            i_brc_less, i_brc_equal, i_stall;
  logic            o_br_un, o_redirect, o_flush_ifid, o_flush_idex, o_illegal;
  logic [XLEN-1:0] o_redirect_pc;
`ifdef BRC_PERF_CNT_EN
  logic [31:0]     o_br_cnt, o_taken_cnt;
`endif

  branch_resolve_ctrl #(.XLEN(XLEN)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_ex_valid    (i_ex_valid),
    .i_ex_is_br    (i_ex_is_br),
    .i_ex_is_jmp   (i_ex_is_jmp),
    .i_ex_is_jalr  (i_ex_is_jalr),
    .i_ex_funct3   (i_ex_funct3),
    .i_ex_target   (i_ex_target),
    .i_brc_less    (i_brc_less),
    .i_brc_equal   (i_brc_equal),
    .i_stall       (i_stall),
    .o_br_un       (o_br_un),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc),
    .o_flush_ifid  (o_flush_ifid),
    .o_flush_idex  (o_flush_idex),
    .o_illegal     (o_illegal)
`ifdef BRC_PERF_CNT_EN
    ,
    .o_br_cnt      (o_br_cnt),
    .o_taken_cnt   (o_taken_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic            redirect;
    logic [XLEN-1:0] pc;
    logic            br_un;
    logic            illegal;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic redir, input logic [XLEN-1:0] pc,
                          input logic brun, input logic ill);
    exp_t e;
    e.redirect = redir;
    e.pc       = pc;
    e.br_un    = brun;
    e.illegal  = ill;
    sb.push_back(e);
  endtask

  task automatic check_outputs(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s scoreboard empty observed=none expected=entry", name);
      return;
    end
    e = sb.pop_front();
    check_bit({name, ".redirect"},   o_redirect,   e.redirect);
    check_bit({name, ".flush_ifid"}, o_flush_ifid, e.redirect);
    check_bit({name, ".flush_idex"}, o_flush_idex, e.redirect);
    check_bit({name, ".illegal"},    o_illegal,    e.illegal);
    check_bit({name, ".br_un"},      o_br_un,      e.br_un);
    if (e.redirect) check_word({name, ".pc"}, o_redirect_pc, e.pc);
  endtask

  task automatic drive(input logic v, br, jmp, jalr, input logic [2:0] f3,
                       input logic [XLEN-1:0] tgt, input logic less, eq, stall);
    i_ex_valid   = v;
    i_ex_is_br   = br;
    i_ex_is_jmp  = jmp;
    i_ex_is_jalr = jalr;
    i_ex_funct3  = f3;
    i_ex_target  = tgt;
    i_brc_less   = less;
    i_brc_equal  = eq;
    i_stall      = stall;
  endtask

  // One cycle: drive at the falling edge, check combinational outputs before the next rising edge.
  task automatic step(input string name,
                      input logic v, br, jmp, jalr, input logic [2:0] f3,
                      input logic [XLEN-1:0] tgt, input logic less, eq, stall,
                      input logic x_redir, input logic [XLEN-1:0] x_pc,
                      input logic x_brun, x_ill);
    @(negedge i_clk);
    drive(v, br, jmp, jalr, f3, tgt, less, eq, stall);
    push_exp(x_redir, x_pc, x_brun, x_ill);
    #2;
    check_outputs(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset_n = 1'b0;
    drive(0, 0, 0, 0, BEQ, '0, 0, 0, 0);
    #1;
    drive(1, 1, 0, 0, BEQ, 32'h100, 0, 1, 0);
    push_exp(0, '0, 0, 0);
    #1 check_outputs("in_reset");
`ifdef BRC_PERF_CNT_EN
    check_word("rst_br_cnt",    o_br_cnt,    32'd0);
    check_word("rst_taken_cnt", o_taken_cnt, 32'd0);
`endif
    @(negedge i_clk);
    drive(0, 0, 0, 0, BEQ, '0, 0, 0, 0);
    i_reset_n = 1'b1;

    //          name            v  br jmp jalr f3      target      lt eq st   redir pc          un ill
    step("beq_taken",       1, 1, 0, 0, BEQ,    32'h100, 0, 1, 0,  1, 32'h100, 0, 0);
    step("bubble_after",    0, 0, 0, 0, BEQ,    32'h100, 0, 1, 0,  0, 32'h0,   0, 0);
    step("bne_eq",          1, 1, 0, 0, BNE,    32'h44,  0, 1, 0,  0, 32'h0,   0, 0);
    step("bne_ne",          1, 1, 0, 0, BNE,    32'h44,  0, 0, 0,  1, 32'h44,  0, 0);
    step("bltu_nt",         1, 1, 0, 0, BLTU,   32'h500, 0, 0, 0,  0, 32'h0,   0, 0);
    step("bge_t",           1, 1, 0, 0, BGE,    32'h300, 0, 0, 0,  1, 32'h300, 1, 0);
    step("blt_t",           1, 1, 0, 0, BLT,    32'h400, 1, 0, 0,  1, 32'h400, 1, 0);
    step("blt_nt",          1, 1, 0, 0, BLT,    32'h400, 0, 0, 0,  0, 32'h0,   1, 0);
    step("bgeu_nt",         1, 1, 0, 0, BGEU,   32'h404, 1, 0, 0,  0, 32'h0,   0, 0);
    step("bltu_t",          1, 1, 0, 0, BLTU,   32'h504, 1, 0, 0,  1, 32'h504, 0, 0);
    step("jal",             1, 0, 1, 0, BEQ,    32'h203, 0, 0, 0,  1, 32'h203, 0, 0);
    step("bubble_br",       0, 1, 0, 0, BEQ,    32'h123, 0, 1, 0,  0, 32'h0,   0, 0);
    step("jalr_stall",      1, 0, 1, 1, BEQ,    32'h203, 0, 0, 1,  0, 32'h0,   0, 0);
    step("pend_hold1",      1, 1, 0, 0, BEQ,    32'h999, 0, 1, 1,  0, 32'h0,   0, 0);
    step("pend_hold2",      1, 1, 0, 0, 3'b010, 32'h888, 0, 0, 1,  0, 32'h0,   0, 0);
    step("pend_release",    1, 1, 0, 0, BEQ,    32'h777, 0, 1, 0,  1, 32'h202, 0, 0);
    step("after_release",   0, 0, 0, 0, BEQ,    32'h0,   0, 0, 0,  0, 32'h0,   0, 0);
    step("illegal_010",     1, 1, 0, 0, 3'b010, 32'h50,  1, 1, 0,  0, 32'h0,   0, 1);
    step("illegal_gone",    0, 0, 0, 0, BEQ,    32'h0,   0, 0, 0,  0, 32'h0,   0, 0);
    step("f3_011_stall",    1, 1, 0, 0, 3'b011, 32'h50,  1, 1, 1,  0, 32'h0,   0, 0);
    step("f3_011",          1, 1, 0, 0, 3'b011, 32'h50,  1, 1, 0,  0, 32'h0,   0, 1);
    step("br_and_jmp",      1, 1, 1, 0, BEQ,    32'h60,  0, 0, 0,  1, 32'h60,  0, 0);
    step("jalr_nostall",    1, 0, 1, 1, BLT,    32'h71,  0, 0, 0,  1, 32'h70,  1, 0);
    step("pend_for_reset",  1, 1, 0, 0, BEQ,    32'h600, 0, 1, 1,  0, 32'h0,   0, 0);

    // Reset lands while PEND would otherwise redirect this cycle.
    @(negedge i_clk);
    drive(0, 0, 0, 0, BEQ, '0, 0, 0, 0);
    #1 i_reset_n = 1'b0;
    push_exp(0, '0, 0, 0);
    #1 check_outputs("reset_mid_pend");
`ifdef BRC_PERF_CNT_EN
    check_word("mid_rst_br_cnt",    o_br_cnt,    32'd0);
    check_word("mid_rst_taken_cnt", o_taken_cnt, 32'd0);
`endif
    @(negedge i_clk);
    i_reset_n = 1'b1;
    step("post_reset1",     0, 0, 0, 0, BEQ,    32'h0,   0, 0, 0,  0, 32'h0,   0, 0);
    step("post_reset2",     0, 0, 0, 0, BEQ,    32'h0,   0, 0, 0,  0, 32'h0,   0, 0);

    step("c_beq_t",         1, 1, 0, 0, BEQ,    32'h10,  0, 1, 0,  1, 32'h10,  0, 0);
    step("c_bne_nt",        1, 1, 0, 0, BNE,    32'h14,  0, 1, 0,  0, 32'h0,   0, 0);
    step("c_blt_t",         1, 1, 0, 0, BLT,    32'h20,  1, 0, 0,  1, 32'h20,  1, 0);
    step("c_bge_nt",        1, 1, 0, 0, BGE,    32'h24,  1, 0, 0,  0, 32'h0,   1, 0);
    step("c_beq_stall",     1, 1, 0, 0, BEQ,    32'h31,  0, 1, 1,  0, 32'h0,   0, 0);
    step("c_pend_out",      0, 0, 0, 0, BEQ,    32'h0,   0, 0, 0,  1, 32'h31,  0, 0);
    step("c_idle",          0, 0, 0, 0, BEQ,    32'h0,   0, 0, 0,  0, 32'h0,   0, 0);
`ifdef BRC_PERF_CNT_EN
    check_word("br_cnt_5",    o_br_cnt,    32'd5);
    check_word("taken_cnt_3", o_taken_cnt, 32'd3);
    @(posedge i_clk);
    #1 dut.br_cnt_q = 32'hFFFF_FFFF;
`endif
    step("c_wrap",          1, 1, 0, 0, BNE,    32'h40,  0, 1, 0,  0, 32'h0,   0, 0);
    step("c_wrap_idle",     0, 0, 0, 0, BEQ,    32'h0,   0, 0, 0,  0, 32'h0,   0, 0);
`ifdef BRC_PERF_CNT_EN
    check_word("br_cnt_wrap",     o_br_cnt,    32'd0);
    check_word("taken_cnt_after", o_taken_cnt, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
